// File: rtl/pipe_rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rca_pkg
// Description : Shared op-encoding constants and the full-adder cell used by
//               the pipelined ripple-carry adder and the ALU decode.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_rca_pkg;

    // Operation encoding on the I_SUB line, shared with the ALU decode
    localparam logic c_OP_ADD = 1'b0;
    localparam logic c_OP_SUB = 1'b1;

    // Full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] full_add(
        input logic i_a,
        input logic i_b,
        input logic i_c
    );
        full_add = {(i_a & i_b) | (i_c & (i_a ^ i_b)), i_a ^ i_b ^ i_c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_rca_rca_n.sv
`default_nettype none
// ============================================================================
// Module      : rca_n
// Description : Combinational N-bit ripple-carry adder built from the
//               full-adder cell. Also exposes the carry into the MSB so the
//               caller can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_n
    import pipe_rca_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_ci,
    output logic [N-1:0] o_sum,
    output logic         o_co,
    output logic         o_cmsb
);

    logic [N:0] w_c;

    // Ripple the carry through one full-adder cell per bit
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < N; i++) begin
            {w_c[i+1], o_sum[i]} = full_add(i_a[i], i_b[i], w_c[i]);
        end
    end

    assign o_co   = w_c[N];
    assign o_cmsb = w_c[N-1];

endmodule
`default_nettype wire

// File: rtl/pipe_rca.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rca
// Description : Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation
//               is split into STAGES equal slices, one slice added per stage,
//               with the carry registered between stages. Valid/ready
//               handshake, one operation per cycle, carry/overflow/zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic             I_CI,
    input  logic             I_SUB,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [WIDTH-1:0] O_SUM,
    output logic             O_CO,
    output logic             O_V,
    output logic             O_Z
);

    localparam int c_SLICE = (STAGES >= 1) ? (WIDTH / STAGES) : 1;

    // Reject configurations that cannot be split into equal slices
    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipe_rca: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
                   WIDTH, STAGES);
        end
    endgenerate

    // Front-end: effective operand B and carry-in
    logic             w_sub;
    logic             w_c0;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_en;

    // Per-stage registers. Operands travel full-width so that each stage
    // picks its own slice; the sum accumulates slice by slice.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_co;
    logic              r_v;
    logic              r_z;

    // Per-stage combinational inputs and results
    logic [WIDTH-1:0]   w_a_in     [STAGES];
    logic [WIDTH-1:0]   w_b_in     [STAGES];
    logic [WIDTH-1:0]   w_s_in     [STAGES];
    logic [WIDTH-1:0]   w_sum_next [STAGES];
    logic [STAGES-1:0]  w_c_in;
    logic [STAGES-1:0]  w_v_in;
    logic [c_SLICE-1:0] w_slice_sum [STAGES];
    logic [STAGES-1:0]  w_slice_co;
    logic               w_slice_cm [STAGES];
    logic               w_z_next;

    assign w_sub   = (I_SUB == c_OP_SUB);
    assign w_b_eff = w_sub ? ~I_B : I_B;
    assign w_c0    = I_CI ^ w_sub;

    // The whole pipe advances together; it only holds when a finished result
    // is waiting and downstream is not taking it.
    assign w_en    = !r_valid[STAGES-1] || I_READY;
    assign O_READY = w_en;

    // Route each stage's inputs: stage 0 from the ports, later stages from the
    // previous stage's registers
    always_comb begin
        w_a_in[0] = I_A;
        w_b_in[0] = w_b_eff;
        w_s_in[0] = '0;
        w_c_in[0] = w_c0;
        w_v_in[0] = I_VALID;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_sum[k-1];
            w_c_in[k] = r_co[k-1];
            w_v_in[k] = r_valid[k-1];
        end
    end

    // One slice adder per stage
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            rca_n #(
                .N (c_SLICE)
            ) u_rca (
                .i_a    (w_a_in[k][k*c_SLICE +: c_SLICE]),
                .i_b    (w_b_in[k][k*c_SLICE +: c_SLICE]),
                .i_ci   (w_c_in[k]),
                .o_sum  (w_slice_sum[k]),
                .o_co   (w_slice_co[k]),
                .o_cmsb (w_slice_cm[k])
            );
        end
    endgenerate

    // Merge each stage's new slice into the partial sum carried forward
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum_next[k] = w_s_in[k];
            w_sum_next[k][k*c_SLICE +: c_SLICE] = w_slice_sum[k];
        end
    end

    // Zero-detect sits on the last stage only, after the final slice lands
    assign w_z_next = (w_sum_next[STAGES-1] == '0);

    // Pipeline registers: clear on reset, shift on enable, data loads only
    // for real operations so the output holds its last result across bubbles
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            r_valid <= '0;
            r_co    <= '0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_en) begin
            r_valid <= w_v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_in[k]) begin
                    r_a[k]   <= w_a_in[k];
                    r_b[k]   <= w_b_in[k];
                    r_sum[k] <= w_sum_next[k];
                    r_co[k]  <= w_slice_co[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_v <= w_slice_cm[STAGES-1] ^ w_slice_co[STAGES-1];
                r_z <= w_z_next;
            end
        end
    end

    assign O_VALID = r_valid[STAGES-1];
    assign O_SUM   = r_sum[STAGES-1];
    assign O_CO    = r_co[STAGES-1];
    assign O_V     = r_v;
    assign O_Z     = r_z;

endmodule
`default_nettype wire
